// File: rtl/ai_compare_sequencer.sv
// Walks load_len template sectors: one read request and one compare per template, tracking the best score.
// mem_req rises 1 cycle after init, done pulses 1 cycle after the final cmp_done; each wait is bounded by TIMEOUT.
module ai_compare_sequencer #(
  parameter int SECTOR_SHIFT = 10,
  parameter int TIMEOUT      = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init,
  input  logic [15:0] i_load_sector,
  input  logic [15:0] i_load_len,
  input  logic [14:0] i_sample_size,
  input  logic [7:0]  i_score_minimum,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [14:0] o_mem_len,
  input  logic        i_mem_ack,
  output logic        o_cmp_start,
  input  logic        i_cmp_done,
  input  logic [7:0]  i_cmp_score,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_best_index,
  output logic [7:0]  o_best_score,
  output logic        o_match,
  output logic        o_error
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CMP, S_FIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_sector;
  logic [15:0]   r_len;
  logic [15:0]   r_idx;
  logic [15:0]   r_best_index;
  logic [14:0]   r_size;
  logic [7:0]    r_min;
  logic [7:0]    r_best_score;
  logic [TW-1:0] r_tmo;
  logic          r_match;
  logic          r_error;
  logic          r_fin_wait;

  logic          w_tmo_hit;
  logic          w_take;
  logic          w_better;
  logic          w_last;
  logic          w_timeout;
  logic          w_enter;
  logic [7:0]    w_best_score_nxt;
  logic [15:0]   w_sector;

  assign w_sector         = r_sector + r_idx;
  assign w_tmo_hit        = (r_tmo == TW'(TIMEOUT));
  assign w_take           = (r_state == S_CMP) && i_cmp_done;
  assign w_better         = (r_idx == 16'd0) || (i_cmp_score > r_best_score);
  assign w_best_score_nxt = w_better ? i_cmp_score : r_best_score;
  assign w_last           = ((r_idx + 16'd1) == r_len);
  assign w_timeout        = w_tmo_hit && (((r_state == S_REQ) && !i_mem_ack) ||
                                          ((r_state == S_CMP) && !i_cmp_done));
  assign w_enter          = (w_state_nxt != r_state) &&
                            ((w_state_nxt == S_REQ) || (w_state_nxt == S_CMP));

  always_comb begin
    w_state_nxt = r_state;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_len   = '0;
    o_cmp_start = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_init) w_state_nxt = (i_load_len == 16'd0) ? S_FIN : S_REQ;
      end
      S_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {16'd0, w_sector} << SECTOR_SHIFT;
        o_mem_len  = r_size;
        if (i_mem_ack)      w_state_nxt = S_CMP;
        else if (w_tmo_hit) w_state_nxt = S_FIN;
      end
      S_CMP: begin
        // The counter is cleared on entry, so zero marks the first CMP cycle.
        o_cmp_start = (r_tmo == '0);
        if (i_cmp_done)     w_state_nxt = w_last ? S_FIN : S_REQ;
        else if (w_tmo_hit) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        o_done = !r_fin_wait;
        if (!r_fin_wait) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sector     <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_size       <= '0;
      r_min        <= '0;
      r_tmo        <= '0;
      r_best_index <= '0;
      r_best_score <= '0;
      r_match      <= 1'b0;
      r_error      <= 1'b0;
      r_fin_wait   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter) r_tmo <= '0;
      else if ((r_state == S_REQ) || (r_state == S_CMP)) r_tmo <= r_tmo + TW'(1);
      if ((r_state == S_IDLE) && i_init) begin
        r_sector     <= i_load_sector;
        r_len        <= i_load_len;
        r_size       <= i_sample_size;
        r_min        <= i_score_minimum;
        r_idx        <= '0;
        r_best_index <= '0;
        r_best_score <= '0;
        r_match      <= 1'b0;
        r_error      <= 1'b0;
        // An empty run spends an extra FIN cycle so done lands two cycles after init.
        r_fin_wait   <= (i_load_len == 16'd0);
      end
      if (w_timeout) r_error <= 1'b1;
      if (w_take) begin
        if (w_better) begin
          r_best_score <= i_cmp_score;
          r_best_index <= r_idx;
        end
        r_idx <= r_idx + 16'd1;
        if (w_last) r_match <= (w_best_score_nxt >= r_min);
      end
      if (r_state == S_FIN) r_fin_wait <= 1'b0;
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_best_index = r_best_index;
  assign o_best_score = r_best_score;
  assign o_match      = r_match;
  assign o_error      = r_error;

endmodule

// File: tb/tb_ai_compare_sequencer.sv
// Bench for ai_compare_sequencer: table vectors, timeout/reset sequences and randomized runs vs. a reference model.
module tb_ai_compare_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_init;
  logic [15:0] i_load_sector;
  logic [15:0] i_load_len;
  logic [14:0] i_sample_size;
  logic [7:0]  i_score_minimum;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [14:0] o_mem_len;
  logic        i_mem_ack;
  logic        o_cmp_start;
  logic        i_cmp_done;
  logic [7:0]  i_cmp_score;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_best_index;
  logic [7:0]  o_best_score;
  logic        o_match;
  logic        o_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ai_compare_sequencer #(.SECTOR_SHIFT(10), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .i_init(i_init), .i_load_sector(i_load_sector),
    .i_load_len(i_load_len), .i_sample_size(i_sample_size), .i_score_minimum(i_score_minimum),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_len(o_mem_len), .i_mem_ack(i_mem_ack),
    .o_cmp_start(o_cmp_start), .i_cmp_done(i_cmp_done), .i_cmp_score(i_cmp_score),
    .o_busy(o_busy), .o_done(o_done), .o_best_index(o_best_index), .o_best_score(o_best_score),
    .o_match(o_match), .o_error(o_error)
  );

  typedef struct {
    logic [15:0] sector;
    logic [15:0] len;
    logic [14:0] size;
    logic [7:0]  smin;
    logic [7:0]  sc [4];
    int          ack_d;
    int          cmp_d;
    logic [15:0] e_idx;
    logic [7:0]  e_score;
    logic        e_match;
  } vec_t;

  vec_t       vt [6];
  logic [7:0] j_sc  [16];
  int         j_ack [16];
  int         j_cmp [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [15:0] se, input logic [15:0] ln,
                         input logic [14:0] sz, input logic [7:0] mn,
                         input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                         input logic [7:0] s3, input int ad, input int cd,
                         input logic [15:0] ei, input logic [7:0] es, input logic em);
    vt[i].sector = se; vt[i].len = ln; vt[i].size = sz; vt[i].smin = mn;
    vt[i].sc[0] = s0; vt[i].sc[1] = s1; vt[i].sc[2] = s2; vt[i].sc[3] = s3;
    vt[i].ack_d = ad; vt[i].cmp_d = cd;
    vt[i].e_idx = ei; vt[i].e_score = es; vt[i].e_match = em;
  endtask

  task automatic scramble_params();
    i_load_sector   = 16'($urandom);
    i_load_len      = 16'($urandom);
    i_sample_size   = 15'($urandom);
    i_score_minimum = 8'($urandom);
  endtask

  // Drives one whole run from IDLE, playing memory and comparer; called and returns at a falling edge.
  task automatic run_job(input logic [15:0] sector, input logic [15:0] len, input logic [14:0] size,
                         input logic [7:0] smin, input logic [15:0] e_idx, input logic [7:0] e_score,
                         input logic e_match, input bit noise);
    int          n;
    logic [15:0] s;
    logic [31:0] exp_addr;
    n = int'(len);
    i_init = 1'b1; i_load_sector = sector; i_load_len = len;
    i_sample_size = size; i_score_minimum = smin;
    @(negedge clk);
    i_init = 1'b0;
    scramble_params();
    if (n == 0) begin
      chk("zero_len_req", 32'(o_mem_req), 0);
      chk("zero_len_busy", 32'(o_busy), 1);
      chk("zero_len_done_early", 32'(o_done), 0);
      @(negedge clk);
      chk("zero_len_req2", 32'(o_mem_req), 0);
    end else begin
      for (int t = 0; t < n; t++) begin
        s = sector + 16'(t);
        exp_addr = {16'd0, s} << 10;
        for (int k = 0; k <= j_ack[t]; k++) begin
          chk("mem_req_hi", 32'(o_mem_req), 1);
          chk("mem_addr", o_mem_addr, exp_addr);
          chk("mem_len", 32'(o_mem_len), 32'(size));
          chk("done_mid_run", 32'(o_done), 0);
          i_mem_ack   = (k == j_ack[t]);
          i_cmp_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          i_cmp_score = 8'hFF;
          i_init      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          @(negedge clk);
        end
        i_mem_ack = 1'b0; i_cmp_done = 1'b0; i_init = 1'b0;
        for (int j = 0; j <= j_cmp[t]; j++) begin
          chk("cmp_start", 32'(o_cmp_start), 32'(j == 0));
          chk("mem_req_lo", 32'(o_mem_req), 0);
          i_cmp_done  = (j == j_cmp[t]);
          i_cmp_score = (j == j_cmp[t]) ? j_sc[t] : 8'($urandom);
          i_mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          i_init      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          @(negedge clk);
        end
        i_cmp_done = 1'b0; i_mem_ack = 1'b0; i_init = 1'b0;
      end
    end
    chk("done", 32'(o_done), 1);
    chk("done_busy", 32'(o_busy), 1);
    chk("best_index", 32'(o_best_index), 32'(e_idx));
    chk("best_score", 32'(o_best_score), 32'(e_score));
    chk("match", 32'(o_match), 32'(e_match));
    chk("error", 32'(o_error), 0);
    chk("fin_req_lo", 32'(o_mem_req), 0);
    @(negedge clk);
    chk("done_once", 32'(o_done), 0);
    chk("idle_busy", 32'(o_busy), 0);
    chk("hold_index", 32'(o_best_index), 32'(e_idx));
    chk("hold_match", 32'(o_match), 32'(e_match));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    int          n;
    int          best;
    logic [15:0] r_sec;
    logic [15:0] r_len;
    logic [15:0] e_i;
    logic [7:0]  r_min;

    set_vec(0, 16'h0002, 16'd3, 15'd256, 8'd80, 8'd40, 8'd90, 8'd90, 8'd0, 2, 1, 16'd1, 8'd90, 1'b1);
    set_vec(1, 16'h0005, 16'd2, 15'd8,   8'd50, 8'd10, 8'd20, 8'd0,  8'd0, 1, 2, 16'd1, 8'd20, 1'b0);
    set_vec(2, 16'hFFFF, 16'd2, 15'd1,   8'd0,  8'd0,  8'd0,  8'd0,  8'd0, 0, 1, 16'd0, 8'd0,  1'b1);
    set_vec(3, 16'h0010, 16'd1, 15'd7,   8'd200, 8'd200, 8'd0, 8'd0, 8'd0, 0, 0, 16'd0, 8'd200, 1'b1);
    set_vec(4, 16'h1234, 16'd4, 15'h7FFF, 8'd251, 8'd7, 8'd250, 8'd3, 8'd251, 3, 0, 16'd3, 8'd251, 1'b1);
    set_vec(5, 16'h0040, 16'd0, 15'd16,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0, 0, 0, 16'd0, 8'd0,  1'b0);

    rst = 1'b1; i_init = 1'b0; i_mem_ack = 1'b0; i_cmp_done = 1'b0; i_cmp_score = 8'd0;
    i_load_sector = 16'd0; i_load_len = 16'd0; i_sample_size = 15'd0; i_score_minimum = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_req", 32'(o_mem_req), 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_len", 32'(o_mem_len), 0);
    chk("rst_cmp_start", 32'(o_cmp_start), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_best_index", 32'(o_best_index), 0);
    chk("rst_best_score", 32'(o_best_score), 0);
    chk("rst_match", 32'(o_match), 0);
    chk("rst_error", 32'(o_error), 0);

    for (int i = 0; i < 6; i++) begin
      for (int t = 0; t < 4; t++) begin
        j_sc[t] = vt[i].sc[t]; j_ack[t] = vt[i].ack_d; j_cmp[t] = vt[i].cmp_d;
      end
      run_job(vt[i].sector, vt[i].len, vt[i].size, vt[i].smin,
              vt[i].e_idx, vt[i].e_score, vt[i].e_match, 1'b0);
    end

    // Read request never acknowledged: mem_req for exactly 17 cycles, then error with done.
    i_init = 1'b1; i_load_sector = 16'h0001; i_load_len = 16'd2;
    i_sample_size = 15'd4; i_score_minimum = 8'd0;
    @(negedge clk);
    i_init = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!o_mem_req) break;
      cnt++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", 32'(cnt), 17);
    chk("timeout_done", 32'(o_done), 1);
    chk("timeout_error", 32'(o_error), 1);
    chk("timeout_match", 32'(o_match), 0);
    @(negedge clk);
    chk("timeout_idle", 32'(o_busy), 0);
    chk("timeout_req_after", 32'(o_mem_req), 0);
    chk("timeout_error_hold", 32'(o_error), 1);

    // Reset while comparing template 1 aborts silently.
    i_init = 1'b1; i_load_sector = 16'h0003; i_load_len = 16'd3;
    i_sample_size = 15'd4; i_score_minimum = 8'd0;
    @(negedge clk);
    i_init = 1'b0; i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0; i_cmp_done = 1'b1; i_cmp_score = 8'd50;
    @(negedge clk);
    i_cmp_done = 1'b0; i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
    chk("pre_rst_cmp_start", 32'(o_cmp_start), 1);
    chk("pre_rst_best_score", 32'(o_best_score), 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_cmp_start", 32'(o_cmp_start), 0);
    chk("abort_mem_req", 32'(o_mem_req), 0);
    chk("abort_mem_addr", o_mem_addr, 0);
    chk("abort_best_score", 32'(o_best_score), 0);
    chk("abort_best_index", 32'(o_best_index), 0);
    for (int c = 0; c < 5; c++) begin
      chk("abort_no_done", 32'(o_done), 0);
      @(negedge clk);
    end
    for (int t = 0; t < 4; t++) begin
      j_sc[t] = vt[0].sc[t]; j_ack[t] = vt[0].ack_d; j_cmp[t] = vt[0].cmp_d;
    end
    run_job(vt[0].sector, vt[0].len, vt[0].size, vt[0].smin,
            vt[0].e_idx, vt[0].e_score, vt[0].e_match, 1'b0);

    // Randomized runs; expectation is the first index holding the maximum score.
    for (int r = 0; r < 40; r++) begin
      n     = $urandom_range(0, 5);
      r_len = 16'(n);
      r_sec = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      r_min = 8'($urandom);
      best  = -1;
      e_i   = 16'd0;
      for (int t = 0; t < n; t++) begin
        j_sc[t]  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(100, 103)) : 8'($urandom);
        j_ack[t] = $urandom_range(0, 4);
        j_cmp[t] = $urandom_range(0, 4);
        if (int'(j_sc[t]) > best) begin
          best = int'(j_sc[t]);
          e_i  = 16'(t);
        end
      end
      if (n == 0)
        run_job(r_sec, r_len, 15'($urandom), r_min, 16'd0, 8'd0, 1'b0, 1'b1);
      else
        run_job(r_sec, r_len, 15'($urandom), r_min, e_i, 8'(best), (best >= int'(r_min)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ai_compare_sequencer.md
AI_COMPARE_SEQUENCER -- requirements
Module: ai_compare_sequencer

Interface
REQ-001 Parameter SECTOR_SHIFT, default 10, log2 of words per template sector.
REQ-002 Parameter TIMEOUT, default 65535, max cycles waited in any wait state.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 init  in  1  one-cycle start pulse.
REQ-006 load_sector  in  16  first template sector number.
REQ-007 load_len  in  16  number of templates to compare.
REQ-008 sample_size  in  15  words per template read.
REQ-009 score_minimum  in  8  match threshold.
REQ-010 mem_req  out  1  template read request, level.
REQ-011 mem_addr  out  32  template base word address.
REQ-012 mem_len  out  15  read length in words.
REQ-013 mem_ack  in  1  read request accepted.
REQ-014 cmp_start  out  1  one-cycle comparer start pulse.
REQ-015 cmp_done  in  1  comparer finished, score valid this cycle.
REQ-016 cmp_score  in  8  comparer score, higher is better.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 best_index  out  16  index (0-based, relative to load_sector) of best template.
REQ-020 best_score  out  8  best score seen.
REQ-021 match  out  1  best_score >= score_minimum, valid from done.
REQ-022 error  out  1  run ended by timeout.

Function
REQ-023 States SHALL be IDLE, REQ, CMP, FIN.
REQ-024 IDLE + init: latch load_sector, load_len, sample_size, score_minimum; clear idx, best_index, best_score, match, error; go REQ, or FIN if load_len==0.
REQ-025 init while busy SHALL be ignored; latched parameters SHALL not change mid-run.
REQ-026 REQ: mem_req=1, mem_addr = zero-extended ((sector_lat + idx) mod 2^16) << SECTOR_SHIFT, mem_len = sample_size latched.
REQ-027 mem_req SHALL stay high until the cycle mem_ack=1 is sampled; mem_req SHALL deassert the following cycle.
REQ-028 On mem_ack, go CMP; cmp_start SHALL be high exactly the first cycle in CMP.
REQ-029 CMP: on cmp_done, if idx==0 or cmp_score > best_score, update best_score=cmp_score, best_index=idx; ties keep lower index.
REQ-030 After cmp_done: idx+1; if idx+1 == load_len go FIN, else REQ; cmp_done in the cmp_start cycle SHALL be accepted.
REQ-031 cmp_done/mem_ack outside CMP/REQ respectively SHALL be ignored.
REQ-032 Timeout counter SHALL clear on entry to REQ/CMP and increment each cycle there; reaching TIMEOUT SHALL set error=1, drop mem_req, go FIN.
REQ-033 FIN: done=1 for one cycle; match = (load_len!=0) && !error && best_score >= score_minimum; then IDLE.
REQ-034 best_index, best_score, match, error SHALL hold until next accepted init.
REQ-035 Latency: init to first mem_req high = 1 cycle; final cmp_done to done = 1 cycle.
REQ-036 load_len==0: done 2 cycles after init, match=0, error=0, mem_req never asserted.

Reset
REQ-037 rst SHALL force IDLE, idx=0, timeout counter=0 and all outputs 0 on the next edge, overriding any in-flight transaction, including mid-REQ/CMP.
REQ-038 No done pulse SHALL be produced for a run aborted by rst.

Verification
REQ-039 init, sector=0x0002, len=3, size=256, mem_ack after 2 cycles, scores 40,90,90, min=80 -> addrs 0x800,0xC00,0x1000, mem_len=256, best_index=1, best_score=90, match=1, one done.
REQ-040 len=2, scores 10,20, min=50 -> best_index=1, best_score=20, match=0, error=0.
REQ-041 len=0 -> no mem_req, done 2 cycles after init, match=0.
REQ-042 TIMEOUT=16, mem_ack held low -> error=1 and done at 17 cycles in REQ, mem_req low after.
REQ-043 second init during CMP -> ignored, original run completes with unchanged params.
REQ-044 rst during CMP of template 1 -> all outputs 0, IDLE, no done; new init restarts from idx 0.
